float_mul_stream: RTL and testbench

//   Fully pipelined IEEE-754-style floating-point multiplier with a parametrised exponent and

---
 rtl/float_pkg.sv | 31 +++
 rtl/float_round_pack.sv | 67 ++++++
 rtl/float_mul_stream.sv | 136 +++++++++++++
 tb/tb_float_mul_stream.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/float_pkg.sv
// Shared float types and helpers for the streaming float arithmetic units.
// The helpers take the field widths as arguments and return 64-bit words that callers size-cast.
package float_pkg;

  typedef enum logic [1:0] {FC_ZERO, FC_NORM, FC_INF, FC_NAN} float_class_t;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
    logic inexact;
  } float_flags_t;

  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic logic [63:0] pack(input logic s, input logic [63:0] e, input logic [63:0] m,
                                       input int exp_w, input int man_w);
    logic [63:0] emask;
    logic [63:0] mmask;
    emask = (64'd1 << exp_w) - 64'd1;
    mmask = (64'd1 << man_w) - 64'd1;
    return (64'(s) << (exp_w + man_w)) | ((e & emask) << man_w) | (m & mmask);
  endfunction

  function automatic logic [63:0] qnan(input int exp_w, input int man_w);
    return pack(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1 << (man_w - 1), exp_w, man_w);
  endfunction

endpackage

// File: rtl/float_round_pack.sv
// Combinational normalise / round-to-nearest-even / special-result select for a raw product.
module float_round_pack
  import float_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int FW = 1 + EXP_W + MAN_W,
  localparam int PW = 2 * MAN_W + 2
) (
  input  logic                    i_sign,
  input  logic signed [EXP_W+1:0] i_exp,
  input  logic [PW-1:0]           i_prod,
  input  float_class_t            i_cls,
  output logic [FW-1:0]           o_res,
  output float_flags_t            o_flags
);
  localparam logic [FW-1:0] QNAN = FW'(qnan(EXP_W, MAN_W));
  localparam logic signed [EXP_W+1:0] EMAX = $signed({2'b00, {EXP_W{1'b1}}});

  logic [PW-1:0]           w_norm;
  logic signed [EXP_W+1:0] w_exp_n, w_exp_f;
  logic [MAN_W:0]          w_mant;
  logic                    w_g, w_r, w_s, w_inc, w_ovf, w_uf;
  logic [MAN_W+1:0]        w_rnd;
  logic [MAN_W-1:0]        w_frac;

  // Product lies in [1,4): align the leading one to the top bit.
  assign w_norm  = i_prod[PW-1] ? i_prod : {i_prod[PW-2:0], 1'b0};
  assign w_exp_n = i_exp + {{(EXP_W+1){1'b0}}, i_prod[PW-1]};
  assign w_mant  = w_norm[PW-1:MAN_W+1];
  assign w_g     = w_norm[MAN_W];
  assign w_r     = w_norm[MAN_W-1];
  assign w_s     = |w_norm[MAN_W-2:0];
  assign w_inc   = w_g & (w_r | w_s | w_mant[0]);
  assign w_rnd   = {1'b0, w_mant} + {{(MAN_W+1){1'b0}}, w_inc};
  assign w_frac  = w_rnd[MAN_W+1] ? w_rnd[MAN_W:1] : w_rnd[MAN_W-1:0];
  assign w_exp_f = w_exp_n + {{(EXP_W+1){1'b0}}, w_rnd[MAN_W+1]};
  assign w_ovf   = (w_exp_f >= EMAX);
  assign w_uf    = w_exp_f[EXP_W+1] | (w_exp_f == '0);

  always_comb begin
    o_flags = '0;
    o_res   = FW'(pack(i_sign, 64'(w_exp_f), 64'(w_frac), EXP_W, MAN_W));
    case (i_cls)
      FC_NAN: begin
        o_res = QNAN;
        o_flags.invalid = 1'b1;
      end
      FC_INF:  o_res = {i_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      FC_ZERO: o_res = {i_sign, {(FW-1){1'b0}}};
      default: begin
        if (w_ovf) begin
          o_res = {i_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          o_flags.overflow = 1'b1;
          o_flags.inexact  = 1'b1;
        end else if (w_uf) begin
          o_res = {i_sign, {(FW-1){1'b0}}};
          o_flags.underflow = 1'b1;
          o_flags.inexact   = 1'b1;
        end else begin
          o_flags.inexact = w_g | w_r | w_s;
        end
      end
    endcase
  end

endmodule

// File: rtl/float_mul_stream.sv
// Streaming float multiplier: capture -> unpack -> multiply -> round/pack, global stall on backpressure.
module float_mul_stream
  import float_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4,
  localparam int FW = 1 + EXP_W + MAN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FW-1:0]    a,
  input  logic [FW-1:0]    b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FW-1:0]    out,
  output logic [TAG_W-1:0] out_tag,
  output logic [3:0]       out_flags,
  output logic             busy
);
  localparam int STAGES = 3;
  localparam int PW = 2 * MAN_W + 2;
  localparam logic [EXP_W+1:0] BIAS = (EXP_W+2)'(bias(EXP_W));

  typedef struct packed {
    logic [FW-1:0]    a;
    logic [FW-1:0]    b;
    logic [TAG_W-1:0] tag;
  } s0_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W+1:0] exp;
    logic [MAN_W:0]   ma;
    logic [MAN_W:0]   mb;
    float_class_t     cls;
    logic [TAG_W-1:0] tag;
  } s1_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W+1:0] exp;
    logic [PW-1:0]    prod;
    float_class_t     cls;
    logic [TAG_W-1:0] tag;
  } s2_t;

  logic [STAGES:0]  r_vld_pipe;
  s0_t              r_s0;
  s1_t              r_s1, w_s1;
  s2_t              r_s2, w_s2;
  logic [FW-1:0]    r_out, w_res;
  logic [TAG_W-1:0] r_out_tag;
  float_flags_t     r_flags, w_flags;
  float_class_t     w_ca, w_cb;
  logic             w_stall;

  function automatic float_class_t classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
    if (e == '0) return FC_ZERO;
    if (&e) return (f != '0) ? FC_NAN : FC_INF;
    return FC_NORM;
  endfunction

  assign w_ca = classify(r_s0.a[FW-2:MAN_W], r_s0.a[MAN_W-1:0]);
  assign w_cb = classify(r_s0.b[FW-2:MAN_W], r_s0.b[MAN_W-1:0]);

  // Denormals classify as zero, so the hidden bit can be forced to 1 unconditionally.
  always_comb begin
    w_s1.sign = r_s0.a[FW-1] ^ r_s0.b[FW-1];
    w_s1.exp  = {2'b00, r_s0.a[FW-2:MAN_W]} + {2'b00, r_s0.b[FW-2:MAN_W]} - BIAS;
    w_s1.ma   = {1'b1, r_s0.a[MAN_W-1:0]};
    w_s1.mb   = {1'b1, r_s0.b[MAN_W-1:0]};
    w_s1.tag  = r_s0.tag;
    if (w_ca == FC_NAN || w_cb == FC_NAN ||
        (w_ca == FC_INF && w_cb == FC_ZERO) || (w_ca == FC_ZERO && w_cb == FC_INF))
      w_s1.cls = FC_NAN;
    else if (w_ca == FC_INF || w_cb == FC_INF)
      w_s1.cls = FC_INF;
    else if (w_ca == FC_ZERO || w_cb == FC_ZERO)
      w_s1.cls = FC_ZERO;
    else
      w_s1.cls = FC_NORM;
  end

  always_comb begin
    w_s2.sign = r_s1.sign;
    w_s2.exp  = r_s1.exp;
    w_s2.prod = r_s1.ma * r_s1.mb;
    w_s2.cls  = r_s1.cls;
    w_s2.tag  = r_s1.tag;
  end

  float_round_pack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round_pack (
    .i_sign  (r_s2.sign),
    .i_exp   ($signed(r_s2.exp)),
    .i_prod  (r_s2.prod),
    .i_cls   (r_s2.cls),
    .o_res   (w_res),
    .o_flags (w_flags)
  );

  assign w_stall = r_vld_pipe[STAGES] & ~out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe <= '0;
      r_s0       <= '0;
      r_s1       <= '0;
      r_s2       <= '0;
      r_out      <= '0;
      r_out_tag  <= '0;
      r_flags    <= '0;
    end else if (!w_stall) begin
      r_vld_pipe <= {r_vld_pipe[STAGES-1:0], in_valid};
      r_s0       <= {a, b, in_tag};
      r_s1       <= w_s1;
      r_s2       <= w_s2;
      if (r_vld_pipe[STAGES-1]) begin
        r_out     <= w_res;
        r_out_tag <= r_s2.tag;
        r_flags   <= w_flags;
      end
    end
  end

  assign in_ready  = ~w_stall;
  assign out_valid = r_vld_pipe[STAGES];
  assign out       = r_out;
  assign out_tag   = r_out_tag;
  assign out_flags = r_flags;
  assign busy      = |r_vld_pipe;

endmodule

// File: tb/tb_float_mul_stream.sv
// Bench for float_mul_stream: directed vectors plus random streams against a real-arithmetic model.
module tb_float_mul_stream;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] a, b, out;
  logic [3:0]  in_tag, out_tag, out_flags;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  float_mul_stream dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .out_tag(out_tag), .out_flags(out_flags), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Exact product via double precision (48-bit mantissa product fits), then RNE to 23 bits.
  function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y);
    logic        s;
    logic [7:0]  ex, ey;
    logic [22:0] fx, fy, keep, frac;
    logic [28:0] rem;
    logic [24:0] m;
    logic [63:0] pb;
    bit          nx, ny, ix, iy, zx, zy, up;
    int          fexp;
    s = x[31] ^ y[31];
    ex = x[30:23]; ey = y[30:23]; fx = x[22:0]; fy = y[22:0];
    nx = (ex == 8'hFF) && (fx != 0); ny = (ey == 8'hFF) && (fy != 0);
    ix = (ex == 8'hFF) && (fx == 0); iy = (ey == 8'hFF) && (fy == 0);
    zx = (ex == 0); zy = (ey == 0);
    if (nx || ny || (ix && zy) || (zx && iy)) return {4'b1000, 32'h7FC00000};
    if (ix || iy) return {4'b0000, s, 8'hFF, 23'h0};
    if (zx || zy) return {4'b0000, s, 31'h0};
    pb = $realtobits(real'({1'b1, fx}) * real'({1'b1, fy}));
    fexp = int'(pb[62:52]) - 1023 + int'(ex) + int'(ey) - 254 - 46 + 127;
    keep = pb[51:29];
    rem  = pb[28:0];
    up = (rem > 29'h1000_0000) || (rem == 29'h1000_0000 && keep[0]);
    m = {2'b01, keep} + 25'(up);
    if (m[24]) fexp++;
    frac = m[24] ? 23'h0 : m[22:0];
    if (fexp >= 255) return {4'b0101, s, 8'hFF, 23'h0};
    if (fexp <= 0) return {4'b0011, s, 31'h0};
    return {3'b000, (rem != 0), s, fexp[7:0], frac};
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [7:0]  e;
    logic [22:0] f;
    int          k;
    k = $urandom_range(0, 15);
    f = 23'($urandom);
    if (k == 0) e = 8'h00;
    else if (k == 1) begin
      e = 8'hFF;
      if ($urandom_range(0, 1) == 0) f = '0;
    end else if (k < 5) e = 8'($urandom_range(1, 254));
    else e = 8'($urandom_range(100, 154));
    return {1'($urandom), e, f};
  endfunction

  task automatic op(input string nm, input logic [31:0] x, input logic [31:0] y,
                    input logic [31:0] exp_o, input logic [3:0] exp_f);
    int lat;
    out_ready = 1'b1; a = x; b = y; in_tag = 4'hA; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_lat"}, lat, 3);
    chk({nm, "_out"}, out, exp_o);
    chk({nm, "_flags"}, 32'(out_flags), 32'(exp_f));
    chk({nm, "_tag"}, 32'(out_tag), 32'hA);
    @(posedge clk); #1;
  endtask

  // Entered and left at posedge+1; inputs set, outputs sampled 1 time unit later.
  task automatic stream(input int n, input bit patterned);
    logic [31:0] q_res[$];
    logic [3:0]  q_fl[$], q_tag[$];
    logic [31:0] opa, opb, held;
    logic [3:0]  held_tag;
    logic [35:0] r;
    int          issued, got, cyc;
    bit          was_stall;
    issued = 0; got = 0; cyc = 0; was_stall = 0; held = '0; held_tag = '0;
    opa = rnd_op(); opb = rnd_op();
    while ((issued < n || got < n) && cyc < 400) begin
      out_ready = patterned ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      in_valid  = (issued < n) && (patterned || $urandom_range(0, 3) != 0);
      a = opa; b = opb; in_tag = 4'(issued);
      #1;
      if (was_stall) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_out", out, held);
        chk("hold_tag", 32'(out_tag), 32'(held_tag));
      end
      was_stall = out_valid && !out_ready;
      if (was_stall) begin
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        held = out; held_tag = out_tag;
      end else chk("in_ready", 32'(in_ready), 32'd1);
      if (out_valid && out_ready) begin
        if (q_res.size() == 0) chk("spurious_out", 32'(out_valid), 32'd0);
        else begin
          chk("stream_out", out, q_res.pop_front());
          chk("stream_flags", 32'(out_flags), 32'(q_fl.pop_front()));
          chk("stream_tag", 32'(out_tag), 32'(q_tag.pop_front()));
          got++;
        end
      end
      if (in_valid && in_ready) begin
        r = model(opa, opb);
        q_res.push_back(r[31:0]); q_fl.push_back(r[35:32]); q_tag.push_back(4'(issued));
        issued++;
        opa = rnd_op(); opb = rnd_op();
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stream_count", got, n);
    chk("stream_leftover", q_res.size(), 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; in_tag = '0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out", out, 32'h0);
    chk("rst_flags", 32'(out_flags), 32'd0);

    op("zero_x_one",  32'h00000000, 32'h3F800000, 32'h00000000, 4'b0000);
    op("nzero_x_one", 32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000);
    op("sq_1p1",      32'h3F8CCCCD, 32'h3F8CCCCD, 32'h3F9AE148, 4'b0001);
    op("neg2000",     32'hC4FA0000, 32'h40200000, 32'hC59C4000, 4'b0000);
    op("overflow",    32'h71800000, 32'h71800000, 32'h7F800000, 4'b0101);
    op("underflow",   32'h0D800000, 32'h0D800000, 32'h00000000, 4'b0011);
    op("inf_x_zero",  32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000);
    op("ninf_x_two",  32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000);

    stream(8, 1'b1);
    stream(60, 1'b0);

    // Reset with three ops in flight.
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = rnd_op(); b = rnd_op(); in_tag = 4'(i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("inflight_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    op("post_rst", 32'h40400000, 32'h40400000, 32'h41100000, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
